// File: rtl/id_pkg.sv
// id_pkg: shared constants and types for the instruction-decode stage.
//   - opcode constants for the base ISA
//   - instruction field bit positions
//   - ID/EX control bundle type and the load-detect helper
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LOAD  = 6'b100011;
  localparam logic [5:0] OP_STORE = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam int INSTR_W = 32;
  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 26;
  localparam int RS_HI   = 25;
  localparam int RS_LO   = 21;
  localparam int RT_HI   = 20;
  localparam int RT_LO   = 16;
  localparam int RD_HI   = 15;
  localparam int RD_LO   = 11;

  // Control half of the ID/EX register; the data half is parameter-sized
  // and lives in the stage itself.
  typedef struct packed {
    logic       vld;
    logic       mem_read;
    logic [5:0] opcode;
  } idex_ctrl_t;

  function automatic logic is_load(input logic [5:0] op, input logic [5:0] load_op);
    return op == load_op;
  endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: bundles the decode stage's IF/ID inputs, write-back
// port, EX-side control and ID/EX register outputs.
//   slave  : the decode stage (drives id_stall and the ID/EX outputs)
//   master : the surrounding pipeline / bench
interface id_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic [31:0]       instructions;
  logic [DATA_W-1:0] IF_ID_PC;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_sel;
  logic [DATA_W-1:0] wb_data;
  logic              ex_stall;
  logic              flush;
  logic              id_stall;
  logic              out_valid;
  logic [DATA_W-1:0] ID_PC;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic [DATA_W-1:0] SE_Imm;
  logic [5:0]        opcode;
  logic [ADDR_W-1:0] rs_out;
  logic [ADDR_W-1:0] rt_out;
  logic [ADDR_W-1:0] rd_out;
  logic              mem_read;

  modport slave (
    input  in_valid, instructions, IF_ID_PC, wb_en, wb_sel, wb_data,
           ex_stall, flush,
    output id_stall, out_valid, ID_PC, readData1, readData2, SE_Imm,
           opcode, rs_out, rt_out, rd_out, mem_read
  );

  modport master (
    output in_valid, instructions, IF_ID_PC, wb_en, wb_sel, wb_data,
           ex_stall, flush,
    input  id_stall, out_valid, ID_PC, readData1, readData2, SE_Imm,
           opcode, rs_out, rt_out, rd_out, mem_read
  );
endinterface

// File: rtl/id_stage_pipe_rf.sv
// reg_file_bypass: 2-read / 1-write register file, 2**ADDR_W entries.
//   clk, rst_n        : clock, async active-low clear of all entries
//   we, waddr, wdata  : write port (writes to entry 0 are dropped)
//   raddr1/2, rdata1/2: combinational read ports; entry 0 reads 0; with
//                       BYPASS=1 a same-cycle write to the read address
//                       is forwarded onto the read data.
module reg_file_bypass #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem;

  // Entry 0 is never written, so it holds its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   mem <= '0;
    else if (we && waddr != '0)   mem[waddr] <= wdata;
  end

  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    if (a == '0)                          return '0;
    if (BYPASS != 0 && we && waddr == a)  return wdata;
    return mem[a];
  endfunction

  always_comb begin
    rdata1 = rd(raddr1);
    rdata2 = rd(raddr2);
  end
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction-decode stage between IF/ID and EX.
//   Clk, Reset : rising-edge clock, async active-low reset
//   bus        : id_stage_pipe_if.slave
//     in        - in_valid, instructions, IF_ID_PC (IF/ID register)
//     in        - wb_en, wb_sel, wb_data (write-back port)
//     in        - ex_stall (hold ID/EX), flush (kill incoming instruction)
//     out       - id_stall (combinational: hold PC and IF/ID)
//     out       - out_valid, ID_PC, readData1/2, SE_Imm, opcode,
//                 rs_out/rt_out/rd_out, mem_read (ID/EX register)
// Decodes fields, reads the register file, sign-extends the immediate and
// registers everything into ID/EX. A load in ID/EX whose rt feeds the
// instruction in ID inserts one bubble.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int         DATA_W  = 32,
  parameter int         ADDR_W  = 5,
  parameter int         IMM_W   = 16,
  parameter int         BYPASS  = 1,
  parameter logic [5:0] LOAD_OP = OP_LOAD
) (
  input  logic           Clk,
  input  logic           Reset,
  id_stage_pipe_if.slave bus
);

  // ---------------- decode ----------------
  logic [5:0]        opc_d;
  logic [ADDR_W-1:0] rs_d, rt_d, rd_d;
  logic [IMM_W-1:0]  imm_d;
  logic [DATA_W-1:0] se_d, rdata1, rdata2;

  assign opc_d = bus.instructions[OPC_HI:OPC_LO];
  // Size casts zero-extend or truncate the 5-bit fields to ADDR_W.
  assign rs_d  = ADDR_W'(bus.instructions[RS_HI:RS_LO]);
  assign rt_d  = ADDR_W'(bus.instructions[RT_HI:RT_LO]);
  assign rd_d  = ADDR_W'(bus.instructions[RD_HI:RD_LO]);
  assign imm_d = bus.instructions[IMM_W-1:0];
  assign se_d  = DATA_W'($signed(imm_d));

  reg_file_bypass #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rf (
    .clk    (Clk),
    .rst_n  (Reset),
    .we     (bus.wb_en),
    .waddr  (bus.wb_sel),
    .wdata  (bus.wb_data),
    .raddr1 (rs_d),
    .raddr2 (rt_d),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  // ---------------- ID/EX register ----------------
  idex_ctrl_t        ctrl_q;
  logic [DATA_W-1:0] pc_q, rd1_q, rd2_q, se_q;
  logic [ADDR_W-1:0] rs_q, rt_q, rd_q;
  logic              hazard;

  // Load in ID/EX writing a register the ID instruction reads.
  assign hazard = bus.in_valid & ctrl_q.vld & ctrl_q.mem_read & (rt_q != '0) &
                  ((rt_q == rs_d) | (rt_q == rt_d));

  // Flush empties ID/EX, so nothing upstream needs to wait. Reset is
  // included so the stall is low while the stage is held in reset.
  assign bus.id_stall = (bus.ex_stall | hazard) & ~bus.flush & Reset;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ctrl_q <= '0;
      pc_q   <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      se_q   <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
    end else if (bus.flush) begin
      ctrl_q.vld <= 1'b0;
    end else if (!bus.ex_stall) begin
      if (hazard) begin
        // Bubble; IF/ID holds, so the same instruction is re-decoded.
        ctrl_q.vld      <= 1'b0;
        ctrl_q.mem_read <= 1'b0;
      end else begin
        ctrl_q.vld      <= bus.in_valid;
        ctrl_q.mem_read <= is_load(opc_d, LOAD_OP) & bus.in_valid;
        ctrl_q.opcode   <= opc_d;
        pc_q            <= bus.IF_ID_PC;
        rd1_q           <= rdata1;
        rd2_q           <= rdata2;
        se_q            <= se_d;
        rs_q            <= rs_d;
        rt_q            <= rt_d;
        rd_q            <= rd_d;
      end
    end
  end

  assign bus.out_valid = ctrl_q.vld;
  assign bus.mem_read  = ctrl_q.mem_read;
  assign bus.opcode    = ctrl_q.opcode;
  assign bus.ID_PC     = pc_q;
  assign bus.readData1 = rd1_q;
  assign bus.readData2 = rd2_q;
  assign bus.SE_Imm    = se_q;
  assign bus.rs_out    = rs_q;
  assign bus.rt_out    = rt_q;
  assign bus.rd_out    = rd_q;

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised instruction-decode stage for the pipelined CPU.
- Splits instruction fields and reads a 2-read/1-write register file with write-through bypass.
- Sign-extends the immediate to DATA_W and registers all results into the ID/EX pipeline register.
- Detects load-use hazards and stalls/flushes under upstream and downstream control; sits between the IF/ID register and EX.

Parameters:
DATA_W, 32, datapath and register width
ADDR_W, 5, register select width; register file depth = 2**ADDR_W
IMM_W, 16, immediate field width, taken from instructions[IMM_W-1:0]
BYPASS, 1, 1 = same-cycle write-back forwarding to read ports; 0 = none
LOAD_OP, 6'b100011, opcode treated as a load for hazard detection

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  asynchronous, active-low (0 = reset)
in_valid  in  1  IF/ID holds a valid instruction
instructions  in  32  instruction word from IF/ID
IF_ID_PC  in  DATA_W  PC of the instruction
wb_en  in  1  write-back enable
wb_sel  in  ADDR_W  write-back register select
wb_data  in  DATA_W  write-back data
ex_stall  in  1  EX cannot accept; hold ID/EX
flush  in  1  kill the instruction entering ID/EX
id_stall  out  1  hold PC and IF/ID (combinational)
out_valid  out  1  ID/EX holds a valid instruction
ID_PC  out  DATA_W  registered PC
readData1  out  DATA_W  registered rs value
readData2  out  DATA_W  registered rt value
SE_Imm  out  DATA_W  registered sign-extended immediate
opcode  out  6  registered instructions[31:26]
rs_out, rt_out, rd_out  out  ADDR_W each  registered register fields
mem_read  out  1  registered (opcode == LOAD_OP)

Behaviour:
- Field extraction:
  - opcode = [31:26]
  - rs = [25:21]
  - rt = [20:16]
  - rd = [15:11]
  - fields are zero-extended or truncated to ADDR_W
- Register file:
  - 2**ADDR_W entries.
  - Write on rising Clk when wb_en=1 and wb_sel!=0.
  - Register 0 always reads 0; writes to it are ignored.
  - Reset clears all entries to 0.
- Read with bypass:
  - If BYPASS=1, wb_en=1, wb_sel==addr and addr!=0, the read returns wb_data in the same cycle.
  - Otherwise the read returns the stored value.
- Sign extension: SE_Imm_next = {(DATA_W-IMM_W) copies of imm[IMM_W-1], imm}.
- hazard (combinational) = in_valid & out_valid & mem_read & (rt_out!=0) & (rt_out==rs | rt_out==rt).
- id_stall = (ex_stall | hazard) & ~flush.
- ID/EX update at each rising Clk, in priority order:
  1. flush: out_valid<=0; other fields don't-care (hold).
  2. ex_stall: hold all ID/EX contents.
  3. hazard: insert bubble, out_valid<=0, mem_read<=0; the IF/ID instruction is re-decoded next cycle.
  4. else: load all decoded values; out_valid<=in_valid; mem_read<=(opcode==LOAD_OP)&in_valid.
- Latency: 1 cycle from IF/ID to ID/EX.
- Load-use costs exactly 1 bubble. After the bubble, the load has left ID/EX and hazard drops.
- Back-to-back loads to the same rt: each dependent instruction stalls once.
- Simultaneous write-back and read of the same register:
  - BYPASS=1: the new value is registered.
  - BYPASS=0: the old value is registered.
- flush and ex_stall together: flush wins; id_stall=0.
- Reset (async, any cycle):
  - all outputs 0: out_valid=0, mem_read=0, ID_PC=0, readData1/2=0, SE_Imm=0, opcode=0, rs/rt/rd_out=0
  - id_stall=0
  - register file cleared
  - takes effect immediately, without waiting for Clk

Decomposition:
- Package id_pkg:
  - opcode constants (OP_RTYPE=6'b000000, OP_LOAD=6'b100011, OP_STORE=6'b101011, OP_BEQ=6'b000100, OP_J=6'b000010)
  - field bit positions (OPC_HI/LO, RS_HI/LO, RT_HI/LO, RD_HI/LO)
  - typedef for the ID/EX bundle
- One sub-module, reg_file_bypass: 2R/1W storage, register-0 hardwiring, BYPASS mux, async active-low clear.
- Hazard logic, sign extension and the ID/EX register stay in the top module.

Test Plan:
- Reset low 20 ns, then high; write 1 to r1 and 2 to r2; issue instructions=32'h0022_1820 with rs=1, rt=2 -> next cycle readData1=1, readData2=2, out_valid=1, rd_out=3.
- Immediate 16'hFFFB (instructions=32'b100100_00000_00001_1111111111111011) -> SE_Imm=32'hFFFF_FFFB; immediate 16'h0010 -> SE_Imm=32'h0000_0010.
- Load rt=4 followed by an instruction with rs=4 -> id_stall=1 for exactly 1 cycle, one bubble (out_valid=0), then the dependent instruction is registered with out_valid=1; with rt=0 instead, no stall.
- wb_en=1, wb_sel=5, wb_data=32'hDEAD_BEEF in the same cycle as a read of r5 -> readData1=32'hDEAD_BEEF when BYPASS=1, old value when BYPASS=0; a write to r0 -> r0 still reads 0.
- ex_stall high 3 cycles -> ID/EX outputs constant and id_stall=1; flush together with ex_stall -> out_valid=0 next edge, id_stall=0.
- Reset driven low mid-stream between clock edges -> all outputs 0 immediately, and after release every register reads 0.
